alu_cmd_sequencer: RTL

//  Parametrised successor to the fixed 6-bit FSM+ALU pair: queued ALU command engine.
//  - Accepts {a,b,op,chain} commands over valid/ready into a DEPTH-entry FIFO.
//  - Executes them in order through an alu_core, one per cycle.
//  - Returns a result plus 5 flags over valid/ready.
//  - Chain mode feeds the previous result back as operand A (accumulator).

---
 rtl/alu_seq_pkg.sv | 35 +++
 rtl/alu_core.sv | 78 +++++++
 rtl/alu_cmd_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, flag bit positions, FSM encoding and queued command control fields
// for the ALU command sequencer.
package alu_seq_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 5;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SHL = 3'b101;
  localparam logic [OP_W-1:0] OP_SHR = 3'b110;
  localparam logic [OP_W-1:0] OP_CMP = 3'b111;

  localparam int unsigned FLG_ZF = 0;
  localparam int unsigned FLG_CF = 1;
  localparam int unsigned FLG_SF = 2;
  localparam int unsigned FLG_OF = 3;
  localparam int unsigned FLG_GT = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Width-independent part of a queued command.
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            chain;
  } cmd_ctrl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: (a, b, op) -> result r plus {GT,OF,SF,CF,ZF} flags.
// Ports: a, b operands; op opcode; r result; flags status bits.
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [OP_W-1:0]   op,
  output logic [WIDTH-1:0]  r,
  output logic [FLAG_W-1:0] flags
);

  localparam int unsigned SH_W = $clog2(WIDTH);
  localparam int unsigned MSB  = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   shr;
  logic [SH_W-1:0]  sh;
  logic             sh_big;
  logic             sub_of;
  logic             cf;
  logic             of;
  logic [WIDTH-1:0] flag_src;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign sub_of = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
  assign sh     = b[SH_W-1:0];
  assign sh_big = 32'(sh) >= WIDTH;
  // One extra bit catches the last bit shifted out; it is zero when sh == 0.
  assign shl    = {1'b0, a} << sh;
  assign shr    = {a, 1'b0} >> sh;

  // Result, carry and overflow per opcode.
  always_comb begin
    r  = '0;
    cf = 1'b0;
    of = 1'b0;
    case (op)
      OP_ADD: begin
        {cf, r} = sum;
        of      = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        {cf, r} = diff;
        of      = sub_of;
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_SHL: if (!sh_big) {cf, r} = shl;
      OP_SHR: if (!sh_big) {r, cf} = shr;
      OP_CMP: begin
        r  = a;
        cf = diff[WIDTH];
        of = sub_of;
      end
      default: r = '0;
    endcase
  end

  // CMP reports the flags of the subtraction while passing A through.
  assign flag_src = (op == OP_CMP) ? diff[WIDTH-1:0] : r;

  always_comb begin
    flags         = '0;
    flags[FLG_ZF] = (flag_src == '0);
    flags[FLG_CF] = cf;
    flags[FLG_SF] = flag_src[MSB];
    flags[FLG_OF] = of;
    flags[FLG_GT] = (flag_src != '0) && !flag_src[MSB];
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queued ALU command engine: commands enter a DEPTH-entry FIFO over valid/ready,
// execute in order one per cycle, and results leave over valid/ready. Chain mode
// takes operand A from the accumulator holding the last produced result.
// Ports: clk, reset_n; cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op/cmd_chain command in;
// flush sync clear; rsp_valid/rsp_ready/rsp_result/rsp_flags result out;
// busy, done (1-cycle idle-entry pulse), cmd_count FIFO occupancy.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           cmd_a,
  input  logic [WIDTH-1:0]           cmd_b,
  input  logic [OP_W-1:0]            cmd_op,
  input  logic                       cmd_chain,
  input  logic                       flush,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_result,
  output logic [FLAG_W-1:0]          rsp_flags,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] cmd_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  a_mem    [DEPTH];
  logic [WIDTH-1:0]  b_mem    [DEPTH];
  cmd_ctrl_t         ctrl_mem [DEPTH];

  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [WIDTH-1:0]  acc;
  state_t            state;
  state_t            state_next;

  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_next;
  logic              rsp_valid_next;
  logic              pending_next;
  logic              done_next;

  cmd_ctrl_t         head;
  logic [WIDTH-1:0]  alu_a;
  logic [WIDTH-1:0]  alu_r;
  logic [FLAG_W-1:0] alu_flags;

  assign empty     = (cmd_count == '0);
  assign full      = (cmd_count == CNT_W'(DEPTH));
  assign cmd_ready = !full && !flush;
  assign push      = cmd_valid && cmd_ready;
  // The head executes whenever the result slot is free or being drained this cycle.
  assign pop       = !empty && (!rsp_valid || rsp_ready) && !flush;
  assign busy      = (state != S_IDLE);

  assign head  = ctrl_mem[rd_ptr];
  assign alu_a = head.chain ? acc : a_mem[rd_ptr];

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a     (alu_a),
    .b     (b_mem[rd_ptr]),
    .op    (head.op),
    .r     (alu_r),
    .flags (alu_flags)
  );

  // Command storage; flush blocks pushes via cmd_ready.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr]    <= cmd_a;
      b_mem[wr_ptr]    <= cmd_b;
      ctrl_mem[wr_ptr] <= '{op: cmd_op, chain: cmd_chain};
    end
  end

  // Next-state, occupancy, response-valid and done pulse.
  always_comb begin
    state_next     = state;
    done_next      = 1'b0;
    count_next     = cmd_count;
    rsp_valid_next = pop || (rsp_valid && !rsp_ready);

    case ({push, pop})
      2'b10:   count_next = cmd_count + CNT_W'(1);
      2'b01:   count_next = cmd_count - CNT_W'(1);
      default: count_next = cmd_count;
    endcase

    pending_next = (count_next != '0) || rsp_valid_next;

    case (state)
      S_IDLE: if (pending_next) state_next = S_EXEC;
      S_EXEC, S_HOLD: begin
        if (!pending_next) begin
          state_next = S_IDLE;
          done_next  = 1'b1;
        end else if (rsp_valid && !rsp_ready) begin
          state_next = S_HOLD;
        end else begin
          state_next = S_EXEC;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (flush) begin
      state_next     = S_IDLE;
      done_next      = 1'b0;
      count_next     = '0;
      rsp_valid_next = 1'b0;
    end
  end

  // State, pointers, response registers and accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cmd_count  <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      acc        <= '0;
      done       <= 1'b0;
    end else begin
      state     <= state_next;
      cmd_count <= count_next;
      rsp_valid <= rsp_valid_next;
      done      <= done_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        acc    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop) begin
          rd_ptr     <= rd_ptr + PTR_W'(1);
          rsp_result <= alu_r;
          rsp_flags  <= alu_flags;
          if (head.op != OP_CMP) acc <= alu_r;
        end
      end
    end
  end

endmodule
